// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key_debounce input-conditioning slice.
// Optional rise_pulse output is enabled by defining KEY_DEBOUNCE_PULSE_EN.
package key_debounce_pkg;

  typedef enum logic {
    KD_IDLE    = 1'b0,
    KD_PENDING = 1'b1
  } kd_state_t;

  localparam int KD_DEFAULT_CYCLES = 1000000;
  localparam int KD_DEFAULT_WIDTH  = 8;

  // Counter only ever reaches cycles-1, so clog2(cycles) bits always suffice.
  function automatic int kdCntWidth(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, polarity normalise, counter FSM.
// Defining KEY_DEBOUNCE_PULSE_EN adds a registered one-cycle rise strobe.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KD_DEFAULT_CYCLES,
  parameter bit INVERT          = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_db
`ifdef KEY_DEBOUNCE_PULSE_EN
  ,
  output logic o_rise
`endif
);

  localparam int              CNT_W    = kdCntWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  kd_state_t        r_state;
  logic             w_s;
  logic             w_commit;

  // Synchroniser resets to the idle pin level so release produces no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= INVERT;
      r_sync2 <= INVERT;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s      = r_sync2 ^ INVERT;
  assign w_commit = (r_state == KD_PENDING) && (w_s != r_db) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= KD_IDLE;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      case (r_state)
        KD_IDLE: begin
          if (w_s != r_db) begin
            r_state <= KD_PENDING;
            r_cnt   <= CNT_W'(1);
          end
        end
        KD_PENDING: begin
          if (w_s == r_db) begin
            r_state <= KD_IDLE;
            r_cnt   <= '0;
          end else if (w_commit) begin
            r_db    <= w_s;
            r_state <= KD_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= KD_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_db = r_db;

`ifdef KEY_DEBOUNCE_PULSE_EN
  logic r_rise;

  // A commit towards 1 is exactly a 0->1 transition of the debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise <= 1'b0;
    end else begin
      r_rise <= w_commit & w_s;
    end
  end

  assign o_rise = r_rise;
`endif

endmodule

// File: rtl/key_debounce.sv
// WIDTH-channel push-button/switch debouncer feeding a PIO in_port.
// Defining KEY_DEBOUNCE_PULSE_EN adds the rise_pulse output.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH           = KD_DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = KD_DEFAULT_CYCLES,
  parameter bit INVERT          = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out
`ifdef KEY_DEBOUNCE_PULSE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse
`endif
);

  if (DEBOUNCE_CYCLES < 2) begin : g_badCyclesLow
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end
  if (DEBOUNCE_CYCLES > (1 << 24)) begin : g_badCyclesHigh
    $error("key_debounce: DEBOUNCE_CYCLES must not exceed 2^24");
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .i_raw  (raw_in[g]),
      .o_db   (db_out[g])
`ifdef KEY_DEBOUNCE_PULSE_EN
      ,
      .o_rise (rise_pulse[g])
`endif
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4; an INVERT=1 and an INVERT=0 instance.
// rise_pulse checks are included only when KEY_DEBOUNCE_PULSE_EN is defined.
module tb_key_debounce;

  logic       clk;
  logic       reset_n;
  logic [7:0] rawIn;
  logic [7:0] dbOut;
  logic [7:0] rawIn2;
  logic [7:0] dbOut2;
`ifdef KEY_DEBOUNCE_PULSE_EN
  logic [7:0] risePulse;
  logic [7:0] risePulse2;
`endif

  int checkCount;
  int passCount;

  key_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .INVERT(1'b1)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (rawIn),
    .db_out    (dbOut)
`ifdef KEY_DEBOUNCE_PULSE_EN
    ,
    .rise_pulse(risePulse)
`endif
  );

  key_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .INVERT(1'b0)) u_dutPass (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (rawIn2),
    .db_out    (dbOut2)
`ifdef KEY_DEBOUNCE_PULSE_EN
    ,
    .rise_pulse(risePulse2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    rawIn   = 8'hFF;
    rawIn2  = 8'h00;
    repeat (3) @(negedge clk);
    checkCount++;
    if (dbOut !== 8'h00) $display("[TB] FAIL reset_hold db_out actual=%h expected=%h", dbOut, 8'h00);
    else passCount++;
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checkCount++;
      if (dbOut !== 8'h00) $display("[TB] FAIL reset_idle cyc%0d db_out actual=%h expected=%h", i, dbOut, 8'h00);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse !== 8'h00) $display("[TB] FAIL reset_idle cyc%0d rise_pulse actual=%h expected=%h", i, risePulse, 8'h00);
      else passCount++;
`endif
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] expDb;
    rawIn[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      expDb = (i >= 6) ? 8'h01 : 8'h00;
      checkCount++;
      if (dbOut !== expDb) $display("[TB] FAIL clean_press edge%0d db_out actual=%h expected=%h", i, dbOut, expDb);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse !== ((i == 6) ? 8'h01 : 8'h00))
        $display("[TB] FAIL clean_press edge%0d rise_pulse actual=%h expected=%h", i, risePulse, (i == 6) ? 8'h01 : 8'h00);
      else passCount++;
`endif
    end
  endtask

  task automatic test_bounce();
    logic [7:0] expDb;
    for (int c = 0; c < 30; c++) begin
      rawIn[1] = ((c % 3) == 2);
      @(negedge clk);
      checkCount++;
      if (dbOut !== 8'h01) $display("[TB] FAIL bounce cyc%0d db_out actual=%h expected=%h", c, dbOut, 8'h01);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse !== 8'h00) $display("[TB] FAIL bounce cyc%0d rise_pulse actual=%h expected=%h", c, risePulse, 8'h00);
      else passCount++;
`endif
    end
    rawIn[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      expDb = (i >= 6) ? 8'h03 : 8'h01;
      checkCount++;
      if (dbOut !== expDb) $display("[TB] FAIL bounce_settle edge%0d db_out actual=%h expected=%h", i, dbOut, expDb);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse !== ((i == 6) ? 8'h02 : 8'h00))
        $display("[TB] FAIL bounce_settle edge%0d rise_pulse actual=%h expected=%h", i, risePulse, (i == 6) ? 8'h02 : 8'h00);
      else passCount++;
`endif
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] expDb;
    rawIn[2] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      expDb = (i >= 6) ? 8'h07 : 8'h03;
      checkCount++;
      if (dbOut !== expDb) $display("[TB] FAIL press_ch2 edge%0d db_out actual=%h expected=%h", i, dbOut, expDb);
      else passCount++;
    end
    rawIn[2] = 1'b1;
    rawIn[3] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      expDb = (i >= 6) ? 8'h0B : 8'h07;
      checkCount++;
      if (dbOut !== expDb) $display("[TB] FAIL simultaneous edge%0d db_out actual=%h expected=%h", i, dbOut, expDb);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse !== ((i == 6) ? 8'h08 : 8'h00))
        $display("[TB] FAIL simultaneous edge%0d rise_pulse actual=%h expected=%h", i, risePulse, (i == 6) ? 8'h08 : 8'h00);
      else passCount++;
`endif
    end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] expDb;
    rawIn[4] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkCount++;
      if (dbOut !== 8'h0B) $display("[TB] FAIL mid_count_pre edge%0d db_out actual=%h expected=%h", i, dbOut, 8'h0B);
      else passCount++;
    end
    reset_n = 1'b0;
    #1;
    checkCount++;
    if (dbOut !== 8'h00) $display("[TB] FAIL mid_count_reset db_out actual=%h expected=%h", dbOut, 8'h00);
    else passCount++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      expDb = (i >= 6) ? 8'h1B : 8'h00;
      checkCount++;
      if (dbOut !== expDb) $display("[TB] FAIL mid_count_release edge%0d db_out actual=%h expected=%h", i, dbOut, expDb);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse !== ((i == 6) ? 8'h1B : 8'h00))
        $display("[TB] FAIL mid_count_release edge%0d rise_pulse actual=%h expected=%h", i, risePulse, (i == 6) ? 8'h1B : 8'h00);
      else passCount++;
`endif
    end
  endtask

  task automatic test_invert_zero();
    logic [7:0] expDb;
    rawIn2 = 8'h81;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      expDb = (i >= 6) ? 8'h81 : 8'h00;
      checkCount++;
      if (dbOut2 !== expDb) $display("[TB] FAIL invert0 edge%0d db_out actual=%h expected=%h", i, dbOut2, expDb);
      else passCount++;
      checkCount++;
      if (dbOut !== 8'h1B) $display("[TB] FAIL invert0_other edge%0d db_out actual=%h expected=%h", i, dbOut, 8'h1B);
      else passCount++;
`ifdef KEY_DEBOUNCE_PULSE_EN
      checkCount++;
      if (risePulse2 !== ((i == 6) ? 8'h81 : 8'h00))
        $display("[TB] FAIL invert0 edge%0d rise_pulse actual=%h expected=%h", i, risePulse2, (i == 6) ? 8'h81 : 8'h00);
      else passCount++;
`endif
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_invert_zero();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
